word_receiver: RTL
==================

WORD_RECEIVER -- requirements
Module: word_receiver

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32: assembled word width.
REQ-002 The block SHALL have parameter NB_BYTE, default 8: byte width; NB_DATA SHALL equal 4*NB_BYTE.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 2604000 (~100 ms at 25 MHz): maximum idle clocks between bytes of one word.
REQ-004 The block SHALL have port i_clock  input  1  sole clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port i_rx_data  input  NB_BYTE  received byte, valid when i_rx_done is high.
REQ-007 The block SHALL have port i_rx_done  input  1  one-cycle pulse from the byte receiver.
REQ-008 The block SHALL have port i_clear  input  1  synchronous abort of any partial word.
REQ-009 The block SHALL have port o_word  output  NB_DATA  last complete word.
REQ-010 The block SHALL have port o_word_valid  output  1  one-cycle pulse: o_word updated.
REQ-011 The block SHALL have port o_byte_count  output  2  bytes held in the current partial word (0..3).
REQ-012 The block SHALL have port o_busy  output  1  high while a partial word is held.
REQ-013 The block SHALL have port o_timeout  output  1  one-cycle pulse: partial word discarded on timeout.

Function
REQ-014 The FSM SHALL have two states: IDLE (no bytes held) and COLLECT (1..3 bytes held).
REQ-015 Byte order SHALL be little-endian: byte k of a word (k=0..3, in arrival order) lands in bits [8k+7:8k].
REQ-016 In IDLE, on i_rx_done, the block SHALL store the byte as byte 0, set count to 1 and enter COLLECT.
REQ-017 In COLLECT, on i_rx_done with count<3, the block SHALL store the byte at index count and increment count.
REQ-018 In COLLECT, on i_rx_done with count==3, the block SHALL load o_word with the full word on the next edge, pulse o_word_valid for exactly that cycle, reset count to 0 and return to IDLE.
REQ-019 Latency SHALL be one clock: o_word and o_word_valid SHALL become visible the cycle after the 4th i_rx_done.
REQ-020 o_word SHALL hold its value until the next complete word; partial bytes SHALL never appear on o_word.
REQ-021 o_busy SHALL be high exactly when the state is COLLECT; o_byte_count SHALL be registered and SHALL read 0 in IDLE.
REQ-022 The timeout counter SHALL clear to 0 on every accepted byte, SHALL increment every clock in COLLECT, and SHALL be held at 0 in IDLE.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 without a byte, the block SHALL discard the partial word, pulse o_timeout for one cycle, set count to 0 and return to IDLE.
REQ-024 The counter width SHALL be $clog2(TIMEOUT_CYCLES) bits, and the counter SHALL never wrap.
REQ-025 If i_rx_done and timeout expiry occur in the same cycle, the byte SHALL be accepted, the counter SHALL clear, and o_timeout SHALL NOT pulse.
REQ-026 i_clear SHALL return the block to IDLE with count 0 and the counter 0, without pulsing o_timeout or o_word_valid.
REQ-027 If i_clear and i_rx_done coincide, i_clear SHALL win and the byte SHALL be discarded; o_word SHALL be unchanged.
REQ-028 i_rx_done held high for several cycles SHALL be counted as one byte per high cycle; the upstream receiver SHALL guarantee single-cycle pulses.
REQ-029 A 4th byte arriving in the same cycle o_word_valid is high SHALL be handled normally, so back-to-back words SHALL be accepted with no gap cycles.

Reset
REQ-030 While i_reset is high, the block SHALL asynchronously force state IDLE, count 0, timeout counter 0, byte buffer 0, o_word 0, and o_word_valid, o_timeout, o_busy and o_byte_count all 0.
REQ-031 Reset asserted mid-word SHALL discard the partial word, and the first i_rx_done after release SHALL be treated as byte 0.

Verification
REQ-032 Bytes 0x78,0x56,0x34,0x12 on four i_rx_done pulses -> o_word=0x12345678 with o_word_valid high for one cycle, one clock after the 4th pulse; o_busy then 0.
REQ-033 Two words sent back-to-back (0xDDCCBBAA, then 0x44332211) -> two valid pulses with the correct o_word each; o_word holds 0x44332211 afterwards.
REQ-034 TIMEOUT_CYCLES=16; send 2 bytes then idle -> o_timeout pulses once, o_byte_count returns to 0; the next 4 bytes form a correct word containing only the new bytes.
REQ-035 TIMEOUT_CYCLES=16; a byte arrives exactly on the expiry cycle -> no o_timeout, count increments, and the word completes correctly.
REQ-036 After 3 bytes, assert i_clear together with i_rx_done -> count 0, no pulses, o_word unchanged; also assert i_reset asynchronously mid-word -> all outputs 0 immediately.

Source files
------------

// File: rtl/word_receiver.sv
// word_receiver: packs four received bytes (little-endian) into one word.
// A partial word is dropped when the gap between bytes exceeds TIMEOUT_CYCLES,
// or when i_clear is asserted. Completed words appear one clock after the 4th byte.
module word_receiver #(
  parameter int unsigned NB_DATA        = 32,       // assembled word width (4 * NB_BYTE)
  parameter int unsigned NB_BYTE        = 8,        // byte width
  parameter int unsigned TIMEOUT_CYCLES = 2604000   // max idle clocks between bytes
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_clear,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid,
  output logic [1:0]         o_byte_count,
  output logic               o_busy,
  output logic               o_timeout
);

  // Guard against a zero-width counter if TIMEOUT_CYCLES is tiny.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    StIdle,
    StCollect
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [1:0]          r_count;
  logic [1:0]          w_count_next;
  logic [TW-1:0]       r_tcnt;
  logic [TW-1:0]       w_tcnt_next;
  logic [NB_DATA-1:0]  r_buf;
  logic [NB_DATA-1:0]  w_buf_next;
  logic [NB_DATA-1:0]  r_word;
  logic [NB_DATA-1:0]  w_word_next;
  logic                r_word_valid;
  logic                w_word_valid_next;
  logic                r_timeout;
  logic                w_timeout_next;

  // State and datapath registers; reset clears everything, including o_word.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_count      <= 2'd0;
      r_tcnt       <= '0;
      r_buf        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_tcnt       <= w_tcnt_next;
      r_buf        <= w_buf_next;
      r_word       <= w_word_next;
      r_word_valid <= w_word_valid_next;
      r_timeout    <= w_timeout_next;
    end
  end

  // Next-state logic: clear beats everything, an arriving byte beats timeout expiry.
  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_tcnt_next       = r_tcnt;
    w_buf_next        = r_buf;
    w_word_next       = r_word;
    w_word_valid_next = 1'b0;
    w_timeout_next    = 1'b0;

    if (i_clear) begin
      w_state_next = StIdle;
      w_count_next = 2'd0;
      w_tcnt_next  = '0;
      w_buf_next   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_tcnt_next = '0;
          if (i_rx_done) begin
            w_buf_next              = '0;
            w_buf_next[NB_BYTE-1:0] = i_rx_data;
            w_count_next            = 2'd1;
            w_state_next            = StCollect;
          end
        end

        StCollect: begin
          if (i_rx_done) begin
            w_tcnt_next = '0;
            if (r_count == 2'd3) begin
              // 4th byte: publish the word straight from the buffer plus this byte.
              w_word_next       = {i_rx_data, r_buf[3*NB_BYTE-1:0]};
              w_word_valid_next = 1'b1;
              w_count_next      = 2'd0;
              w_buf_next        = '0;
              w_state_next      = StIdle;
            end else begin
              w_buf_next[int'(r_count)*NB_BYTE +: NB_BYTE] = i_rx_data;
              w_count_next = 2'(r_count + 2'd1);
            end
          end else if (r_tcnt == TMAX) begin
            w_timeout_next = 1'b1;
            w_count_next   = 2'd0;
            w_tcnt_next    = '0;
            w_buf_next     = '0;
            w_state_next   = StIdle;
          end else begin
            // Cannot wrap: TMAX is always caught above.
            w_tcnt_next = r_tcnt + 1'b1;
          end
        end

        default: begin
          w_state_next = StIdle;
          w_count_next = 2'd0;
          w_tcnt_next  = '0;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    o_word       = r_word;
    o_word_valid = r_word_valid;
    o_byte_count = r_count;
    o_busy       = (r_state == StCollect);
    o_timeout    = r_timeout;
  end

endmodule
